// File: rtl/vx_scope_host.sv
// Host side of the scope debug bus: serialises 64-bit commands onto bus_out
// and deserialises the taps' 64-bit reply from bus_in, with a response timeout.
module vx_scope_host #(
  parameter int SCOPE_IDW = 8,
  parameter int TIMEOUT   = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_type,
  input  logic [SCOPE_IDW-1:0]  req_scope_id,
  input  logic [60-SCOPE_IDW:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [63:0]           rsp_data,
  output logic                  rsp_timeout,
  output logic                  bus_out,
  input  logic                  bus_in
);

  localparam int WCW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    TX,
    GUARD,
    WAIT,
    RX,
    RSP
  } state_e;

  state_e          state_q, state_d;
  logic [63:0]     cmd_q, cmd_d;
  logic [5:0]      bit_cnt_q, bit_cnt_d;
  logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
  logic            bus_out_q, bus_out_d;
  logic [63:0]     rsp_data_q, rsp_data_d;
  logic            rsp_timeout_q, rsp_timeout_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cmd_q         <= '0;
      bit_cnt_q     <= '0;
      wait_cnt_q    <= '0;
      bus_out_q     <= 1'b0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      bit_cnt_q     <= bit_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      bus_out_q     <= bus_out_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    bit_cnt_d     = bit_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    bus_out_d     = bus_out_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        bus_out_d = 1'b0;
        if (req_valid) begin
          cmd_d     = {req_data, req_scope_id, req_type};
          bus_out_d = 1'b1;
          bit_cnt_d = 6'd63;
          state_d   = TX;
        end
      end

      TX: begin
        bus_out_d = cmd_q[bit_cnt_q];
        if (bit_cnt_q == 6'd0) begin
          bit_cnt_d = 6'd2;
          state_d   = GUARD;
        end else begin
          bit_cnt_d = bit_cnt_q - 6'd1;
        end
      end

      // First GUARD cycle still shows bit 0 on the registered line; the
      // following two cycles hold the line low before anything new can start.
      GUARD: begin
        bus_out_d = 1'b0;
        if (bit_cnt_q == 6'd0) begin
          if (cmd_q[2] == 1'b0) begin
            wait_cnt_d = '0;
            state_d    = WAIT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - 6'd1;
        end
      end

      WAIT: begin
        if (bus_in) begin
          bit_cnt_d = 6'd63;
          state_d   = RX;
        end else if (wait_cnt_q == WCW'(TIMEOUT - 1)) begin
          rsp_timeout_d = 1'b1;
          rsp_data_d    = '0;
          state_d       = RSP;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end

      RX: begin
        rsp_data_d = {rsp_data_q[62:0], bus_in};
        if (bit_cnt_q == 6'd0) begin
          state_d = RSP;
        end else begin
          bit_cnt_d = bit_cnt_q - 6'd1;
        end
      end

      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          rsp_timeout_d = 1'b0;
          state_d       = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus_out     = bus_out_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_vx_scope_host.sv
// Randomised bench for vx_scope_host: a cycle-timeline model of the host
// protocol is checked against the DUT every cycle, plus literal spot checks.
module tb_vx_scope_host;

  localparam int SCOPE_IDW = 8;
  localparam int TIMEOUT   = 256;
  localparam int DW        = 61 - SCOPE_IDW;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 req_valid;
  logic                 req_ready;
  logic [2:0]           req_type;
  logic [SCOPE_IDW-1:0] req_scope_id;
  logic [DW-1:0]        req_data;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [63:0]          rsp_data;
  logic                 rsp_timeout;
  logic                 bus_out;
  logic                 bus_in;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  vx_scope_host #(.SCOPE_IDW(SCOPE_IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_type     (req_type),
    .req_scope_id (req_scope_id),
    .req_data     (req_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_timeout  (rsp_timeout),
    .bus_out      (bus_out),
    .bus_in       (bus_in)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
  endtask

  // Timeline model: everything is expressed relative to the acceptance cycle
  // mT; the reply window opens at mT+68 for the four GET types.
  bit          live = 0, mBusy = 0, mGet = 0, mKnown = 0, mTo = 0;
  int          mT = 0, mStart = -1, mRspAt = 0;
  logic [63:0] mWord = '0, mData = '0;

  always @(negedge clk) begin
    int   d;
    logic expBus;
    if (live) begin
      if (!mBusy) begin
        checkOutput("req_ready_idle", 65'(req_ready), 65'd1);
        checkOutput("bus_out_idle", 65'(bus_out), 65'd0);
        checkOutput("rsp_valid_idle", 65'(rsp_valid), 65'd0);
      end else begin
        d = cyc - mT;
        if (d == 1) expBus = 1'b1;
        else if (d >= 2 && d <= 65) expBus = mWord[65-d];
        else expBus = 1'b0;
        checkOutput("req_ready_busy", 65'(req_ready), 65'd0);
        checkOutput("bus_out", 65'(bus_out), 65'(expBus));
        if (mKnown && cyc >= mRspAt) begin
          checkOutput("rsp_valid", 65'(rsp_valid), 65'd1);
          checkOutput("rsp_data", 65'(rsp_data), 65'(mData));
          checkOutput("rsp_timeout", 65'(rsp_timeout), 65'(mTo));
        end else begin
          checkOutput("rsp_valid_early", 65'(rsp_valid), 65'd0);
        end
      end
    end

    if (reset) begin
      mBusy  = 0;
      mKnown = 0;
    end else if (!mBusy) begin
      if (req_valid) begin
        mBusy  = 1;
        mT     = cyc;
        mWord  = {req_data, req_scope_id, req_type};
        mGet   = (req_type < 3'd4);
        mKnown = 0;
        mStart = -1;
        mData  = '0;
        mTo    = 0;
      end
    end else begin
      d = cyc - mT;
      if (!mGet) begin
        if (d == 67) mBusy = 0;
      end else if (!mKnown) begin
        if (cyc >= mT + 68) begin
          if (mStart < 0) begin
            if (bus_in === 1'b1) mStart = cyc;
            else if (cyc - (mT + 68) == TIMEOUT - 1) begin
              mKnown = 1; mRspAt = cyc + 1; mTo = 1; mData = '0;
            end
          end else begin
            mData = {mData[62:0], bus_in};
            if (cyc == mStart + 64) begin
              mKnown = 1; mRspAt = cyc + 1;
            end
          end
        end
      end else if (cyc >= mRspAt && rsp_ready) begin
        mBusy = 0;
      end
    end

    if (reset) live = 1;
  end

  task automatic sendCmd(input logic [2:0] t, input logic [7:0] sid, input logic [DW-1:0] dat,
                         input bit hold, output int tAcc);
    bit ok = 0;
    tAcc = 0;
    req_type = t; req_scope_id = sid; req_data = dat; req_valid = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin ok = 1; tAcc = cyc; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      checks++;
      $display("[TB] FAIL accept_wait: req_ready never seen, expected within 600 cycles");
    end
    @(posedge clk); #1;
    if (!hold) begin
      req_valid    = 1'b0;
      req_type     = 3'($urandom);
      req_scope_id = 8'($urandom);
      req_data     = DW'({$urandom, $urandom});
    end
  endtask

  // Called in cycle T+1; returns in cycle T+68 with the 65-bit frame seen.
  task automatic runFrame(output logic [64:0] frame, output logic rdy67);
    frame = '0;
    rdy67 = 1'b0;
    for (int k = 1; k <= 67; k++) begin
      if (k <= 65) frame = {frame[63:0], bus_out};
      if (k == 67) rdy67 = req_ready;
      bus_in = 1'($urandom);
      @(posedge clk); #1;
    end
    bus_in = 1'b0;
  endtask

  task automatic runTap(input int delay, input logic [63:0] word);
    if (delay >= 0) begin
      repeat (delay) begin bus_in = 1'b0; @(posedge clk); #1; end
      bus_in = 1'b1; @(posedge clk); #1;
      for (int i = 63; i >= 0; i--) begin bus_in = word[i]; @(posedge clk); #1; end
    end
    bus_in = 1'b0;
  endtask

  task automatic waitRsp(input int readyDelay, output int waited, output logic [63:0] d, output logic to);
    bit ok = 0;
    waited = 0; d = '0; to = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin ok = 1; break; end
      waited++;
      @(posedge clk); #1;
    end
    if (!ok) begin
      checks++;
      $display("[TB] FAIL rsp_wait: rsp_valid never seen, expected within 400 cycles");
      return;
    end
    d = rsp_data; to = rsp_timeout;
    repeat (readyDelay - 1) begin @(posedge clk); #1; bus_in = 1'($urandom); end
    @(posedge clk); #1; rsp_ready = 1'b1; bus_in = 1'b0;
    @(posedge clk); #1; rsp_ready = 1'b0;
    checkOutput("idle_after_rsp", 65'(req_ready), 65'd1);
  endtask

  task automatic applyStimulus(input logic [2:0] t, input logic [7:0] sid, input logic [DW-1:0] dat,
                               input int delay, input logic [63:0] word, input int readyDelay,
                               output logic [64:0] frame, output int waited,
                               output logic [63:0] d, output logic to);
    int   tAcc;
    logic rdy67;
    waited = 0; d = '0; to = 1'b0;
    sendCmd(t, sid, dat, 1'b0, tAcc);
    runFrame(frame, rdy67);
    if (t < 3'd4) begin
      runTap(delay, word);
      waitRsp(readyDelay, waited, d, to);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [64:0] frame;
    logic [63:0] d;
    logic        to, rdy67;
    int          waited, t1, t2;

    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; bus_in = 1'b0;
    req_type = '0; req_scope_id = '0; req_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_req_ready", 65'(req_ready), 65'd1);
    checkOutput("reset_bus_out", 65'(bus_out), 65'd0);
    checkOutput("reset_rsp_data", 65'(rsp_data), 65'd0);
    checkOutput("reset_rsp_timeout", 65'(rsp_timeout), 65'd0);
    @(posedge clk); #1;

    $display("[TB] GET_WIDTH scope 0x05, tap replies 0x2A");
    sendCmd(3'd0, 8'h05, '0, 1'b0, t1);
    checkOutput("model_word", 65'(mWord), 65'h28);
    runFrame(frame, rdy67);
    checkOutput("get_width_frame", frame, {1'b1, 64'h28});
    runTap(5, 64'h2A);
    waitRsp(1, waited, d, to);
    checkOutput("get_width_data", 65'(d), 65'h2A);
    checkOutput("get_width_timeout", 65'(to), 65'd0);

    $display("[TB] SET_START data 10, no response");
    sendCmd(3'd4, 8'h11, DW'(10), 1'b0, t1);
    runFrame(frame, rdy67);
    checkOutput("set_start_frame", frame, {1'b1, 64'h508C});
    checkOutput("set_ready_t67", 65'(rdy67), 65'd0);
    checkOutput("set_ready_t68", 65'(req_ready), 65'd1);
    repeat (20) begin bus_in = 1'($urandom); @(posedge clk); #1; end
    bus_in = 1'b0;

    $display("[TB] GET_COUNT to absent scope, expect timeout");
    applyStimulus(3'd1, 8'h7E, DW'(3), -1, '0, 1, frame, waited, d, to);
    checkOutput("timeout_latency", 65'(waited), 65'd256);
    checkOutput("timeout_flag", 65'(to), 65'd1);
    checkOutput("timeout_data", 65'(d), 65'd0);

    $display("[TB] GET_DATA reply held for 10 cycles");
    applyStimulus(3'd3, 8'h22, DW'(7), 0, 64'h8000_0000_0000_0001, 10, frame, waited, d, to);
    checkOutput("get_data_value", 65'(d), 65'h8000_0000_0000_0001);

    $display("[TB] reset in the middle of a TX frame");
    sendCmd(3'd0, 8'h33, DW'(1), 1'b0, t1);
    repeat (29) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_bus_out", 65'(bus_out), 65'd0);
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_req_ready", 65'(req_ready), 65'd1);
    applyStimulus(3'd2, 8'h44, DW'(99), 12, 64'hDEAD_BEEF_0123_4567, 2, frame, waited, d, to);
    checkOutput("after_abort_data", 65'(d), 65'hDEAD_BEEF_0123_4567);

    $display("[TB] back-to-back SET_STOP then GET_START");
    sendCmd(3'd5, 8'h55, DW'(4), 1'b1, t1);
    req_type = 3'd2; req_scope_id = 8'h66; req_data = DW'(5);
    runFrame(frame, rdy67);
    sendCmd(3'd2, 8'h66, DW'(5), 1'b0, t2);
    checkOutput("b2b_gap", 65'(t2 - t1), 65'd68);
    runFrame(frame, rdy67);
    runTap(3, 64'h0F0F_1234_5678_9ABC);
    waitRsp(3, waited, d, to);

    $display("[TB] randomised transactions");
    for (int n = 0; n < 8; n++) begin
      logic [63:0] w;
      int          dly;
      w   = {$urandom, $urandom};
      dly = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 40));
      applyStimulus(3'($urandom), 8'($urandom), DW'({$urandom, $urandom}), dly, w,
                    int'($urandom_range(1, 5)), frame, waited, d, to);
      repeat (int'($urandom_range(0, 3))) begin @(posedge clk); #1; end
    end

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
